// File: rtl/csr_test_host_if.sv
// Avalon-MM command/response bundle between the CSR test host and the
// memory-checker CSR block.
interface csr_test_host_if;
    logic        read_o;
    logic        write_o;
    logic [3:0]  address_o;
    logic [31:0] writedata_o;
    logic        readdatavalid_i;
    logic [31:0] readdata_i;

    modport master (
        output read_o, write_o, address_o, writedata_o,
        input  readdatavalid_i, readdata_i
    );

    modport slave (
        input  read_o, write_o, address_o, writedata_o,
        output readdatavalid_i, readdata_i
    );
endinterface

// File: rtl/csr_test_host.sv
// Avalon-MM master that writes test parameters, kicks the checker, polls for
// finish (with gap and poll limit) and collects the result registers.
module csr_test_host #(
    parameter int PARAM_CNT   = 4,
    parameter int FINISH_ADDR = 5,
    parameter int RES_FIRST   = 6,
    parameter int RES_CNT     = 4,
    parameter int POLL_GAP    = 16,
    parameter int POLL_MAX    = 1024
) (
    input  logic                       clk_sys_i,
    input  logic                       rst_sys_n_i,
    input  logic                       run_i,
    input  logic [PARAM_CNT-1:0][31:0] param_i,
    csr_test_host_if.master            bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic [RES_CNT-1:0][31:0]   result_o
);

    // state     | meaning
    // IDLE      | waiting for run_i
    // WR_PARAM  | writing parameter idx to address idx+1
    // WR_START  | writing 1 to address 0 (self-clearing start)
    // POLL_RD   | read of the finish register
    // POLL_WAIT | waiting for finish read data
    // POLL_GAP  | idle cycles between polls
    // RES_RD    | read of result register idx
    // RES_WAIT  | waiting for result read data
    // DONE      | one-cycle completion pulse
    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_PARAM, ST_WR_START, ST_POLL_RD, ST_POLL_WAIT,
        ST_POLL_GAP, ST_RES_RD, ST_RES_WAIT, ST_DONE
    } state_t;

    localparam int IDX_MAX  = (PARAM_CNT > RES_CNT) ? PARAM_CNT : RES_CNT;
    localparam int IDX_W    = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
    localparam int PC_W     = $clog2(POLL_MAX + 1);
    localparam int GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_LOAD = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    state_t                     state, state_nxt;
    logic [IDX_W-1:0]           idx;
    logic [PC_W-1:0]            poll_cnt;
    logic [GAP_W-1:0]           gap_cnt;
    logic [PARAM_CNT-1:0][31:0] param_q;
    logic                       rd, wr;
    logic [3:0]                 addr;
    logic [31:0]                wdata;
    logic                       poll_limit;

    assign poll_limit = (poll_cnt == PC_W'(POLL_MAX));

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        wr        = 1'b0;
        addr      = '0;
        wdata     = '0;
        case (state)
            ST_IDLE:      if (run_i) state_nxt = ST_WR_PARAM;
            ST_WR_PARAM: begin
                wr    = 1'b1;
                addr  = 4'(idx) + 4'd1;
                wdata = param_q[idx];
                if (idx == IDX_W'(PARAM_CNT - 1)) state_nxt = ST_WR_START;
            end
            ST_WR_START: begin
                wr        = 1'b1;
                wdata     = 32'h1;
                state_nxt = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                rd        = 1'b1;
                addr      = 4'(FINISH_ADDR);
                state_nxt = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (bus.readdatavalid_i) begin
                    if (bus.readdata_i[0])  state_nxt = ST_RES_RD;
                    else if (poll_limit)    state_nxt = ST_DONE;
                    else if (POLL_GAP == 0) state_nxt = ST_POLL_RD;
                    else                    state_nxt = ST_POLL_GAP;
                end
            end
            ST_POLL_GAP:  if (gap_cnt == '0) state_nxt = ST_POLL_RD;
            ST_RES_RD: begin
                rd        = 1'b1;
                addr      = 4'(RES_FIRST) + 4'(idx);
                state_nxt = ST_RES_WAIT;
            end
            ST_RES_WAIT: begin
                if (bus.readdatavalid_i)
                    state_nxt = (idx == IDX_W'(RES_CNT - 1)) ? ST_DONE : ST_RES_RD;
            end
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_n_i) begin
            state     <= ST_IDLE;
            idx       <= '0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            param_q   <= '0;
            timeout_o <= 1'b0;
            result_o  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (run_i) begin
                        param_q   <= param_i;
                        timeout_o <= 1'b0;
                        poll_cnt  <= '0;
                        idx       <= '0;
                    end
                end
                ST_WR_PARAM: begin
                    if (idx == IDX_W'(PARAM_CNT - 1)) idx <= '0;
                    else                              idx <= idx + IDX_W'(1);
                end
                ST_POLL_RD: begin
                    if (!poll_limit) poll_cnt <= poll_cnt + PC_W'(1);
                end
                ST_POLL_WAIT: begin
                    if (bus.readdatavalid_i) begin
                        if (bus.readdata_i[0]) idx       <= '0;
                        else if (poll_limit)   timeout_o <= 1'b1;
                        else                   gap_cnt   <= GAP_W'(GAP_LOAD);
                    end
                end
                ST_POLL_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
                end
                ST_RES_WAIT: begin
                    if (bus.readdatavalid_i) begin
                        result_o[idx] <= bus.readdata_i;
                        idx           <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read_o      = rd;
    assign bus.write_o     = wr;
    assign bus.address_o   = addr;
    assign bus.writedata_o = wdata;
    assign busy_o          = (state != ST_IDLE);
    assign done_o          = (state == ST_DONE);

endmodule
